pixel_readout_ctrl: RTL and testbench

Readout controller for the hierarchical pixel arbiter. It gates the arbiter's `enable_i` and captures each newly granted pixel address together with a timestamp. Captured events go into an internal first-word-fall-through FIFO, which drains to the downstream event link over a valid/ready handshake. It throttles arbitration when the FIFO nears full, counts events lost to overflow, and sequences a clean drain on stop.

---
 rtl/pixel_readout_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_ctrl.sv
// Readout controller for the hierarchical pixel arbiter: gates arbitration,
// timestamps each new grant and queues it in a FWFT FIFO toward the event link.
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   start_i       : level, 1 = read out, 0 = stop and drain
//   arb_active_i  : arbiter grant valid
//   arb_x_add_i   : granted row address
//   arb_y_add_i   : granted column address
//   arb_enable_o  : registered enable toward the arbiter
//   evt_data_o    : FIFO head {ts, x, y}, zero while empty
//   evt_valid_o   : FIFO non-empty
//   evt_ready_i   : downstream accepts the head
//   fifo_level_o  : FIFO occupancy
//   drop_cnt_o    : saturating count of events lost to a full FIFO
//   busy_o        : controller not idle
module pixel_readout_ctrl #(
    parameter int ROW_ADD    = 2,
    parameter int COL_ADD    = 2,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic                                  arb_active_i,
    input  logic [ROW_ADD-1:0]                    arb_x_add_i,
    input  logic [COL_ADD-1:0]                    arb_y_add_i,
    output logic                                  arb_enable_o,
    output logic [TS_WIDTH+ROW_ADD+COL_ADD-1:0]   evt_data_o,
    output logic                                  evt_valid_o,
    input  logic                                  evt_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level_o,
    output logic [DROP_W-1:0]                     drop_cnt_o,
    output logic                                  busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int AD = ROW_ADD + COL_ADD;
    localparam int EW = TS_WIDTH + AD;

    localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] C_HI   = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [AW:0] C_LO   = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_arb_en;
    logic [TS_WIDTH-1:0] r_ts;
    logic [DROP_W-1:0]   r_drop;
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic                r_act_d;
    logic [AD-1:0]       r_last_addr;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];

    logic [AD-1:0]       w_addr;
    logic [AW:0]         w_level;
    logic [AW:0]         w_level_nxt;
    logic                w_empty;
    logic                w_full;
    logic                w_cap;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_addr  = {arb_x_add_i, arb_y_add_i};
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == C_FULL);

    // A held grant is captured once; a new address or a fresh rise re-arms.
    assign w_cap  = (r_state != S_IDLE) && arb_active_i &&
                    (!r_act_d || (w_addr != r_last_addr));
    assign w_pop  = !w_empty && evt_ready_i;
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && w_full && !w_pop;

    always_comb begin
        w_level_nxt = w_level;
        if (w_push && !w_pop) begin
            w_level_nxt = w_level + C_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = w_level - C_ONE;
        end
    end

    // Thresholds look at the post-edge level so the enable reacts in the
    // same edge that makes the FIFO nearly full (or drained enough).
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!start_i)                w_state_nxt = S_DRAIN;
                else if (w_level_nxt >= C_HI) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!start_i)                w_state_nxt = S_DRAIN;
                else if (w_level_nxt <= C_LO) w_state_nxt = S_RUN;
            end
            S_DRAIN: begin
                if (w_level_nxt == '0 && !arb_active_i) w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_IDLE;
            r_arb_en    <= 1'b0;
            r_ts        <= '0;
            r_drop      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_act_d     <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_arb_en <= (w_state_nxt == S_RUN);
            r_act_d  <= arb_active_i;

            if (r_state == S_IDLE) r_ts <= '0;
            else                   r_ts <= r_ts + TS_WIDTH'(1);

            if (r_state == S_IDLE && start_i) begin
                r_drop <= '0;
            end else if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end

            if (w_cap)  r_last_addr <= w_addr;
            if (w_push) r_wr_ptr    <= r_wr_ptr + C_ONE;
            if (w_pop)  r_rd_ptr    <= r_rd_ptr + C_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_ts, w_addr};
    end

    assign arb_enable_o = r_arb_en;
    assign evt_valid_o  = !w_empty;
    assign evt_data_o   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level_o = w_level;
    assign drop_cnt_o   = r_drop;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: scoreboard of expected events
// checked at the output handshake, plus per-scenario control checks.
module tb_pixel_readout_ctrl;

    localparam int EW = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       active;
    logic [1:0] ax;
    logic [1:0] ay;
    logic       enable;
    logic [EW-1:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] level;
    logic [7:0] drop;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] e_mon;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    pixel_readout_ctrl dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .start_i      (start),
        .arb_active_i (active),
        .arb_x_add_i  (ax),
        .arb_y_add_i  (ay),
        .arb_enable_o (enable),
        .evt_data_o   (evt_data),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .fifo_level_o (level),
        .drop_cnt_o   (drop),
        .busy_o       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Event expected for a grant driven now: ts is cycles since the start edge.
    function automatic logic [EW-1:0] ev(input logic [3:0] a);
        return {16'(cyc - t0), a};
    endfunction

    task automatic drive(input logic [3:0] a);
        active = 1'b1;
        {ax, ay} = a;
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected got=%h exp=none", evt_data);
            end else begin
                e_mon = exp_q.pop_front();
                if (evt_data !== e_mon) begin
                    errors++;
                    $display("FAIL evt_data got=%h exp=%h", evt_data, e_mon);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 0; active = 0; ax = 0; ay = 0; evt_ready = 0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({enable, evt_valid, evt_data, level, drop, busy} !== '0) begin
            errors++;
            $display("FAIL reset_in got=%b%b %h %0d %0d %b exp=all zero",
                     enable, evt_valid, evt_data, level, drop, busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({enable, evt_valid, evt_data, level, drop, busy} !== '0) begin
            errors++;
            $display("FAIL reset_rel got=%b%b %h %0d %0d %b exp=all zero",
                     enable, evt_valid, evt_data, level, drop, busy);
        end
    endtask

    task automatic test_basic_capture();
        int nv;
        start = 1'b1;
        tick();
        t0 = cyc;
        checks++;
        if (enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_en got=%b/%b exp=1/1", enable, busy);
        end
        evt_ready = 1'b1;
        drive(4'b1001);
        exp_q.push_back(ev(4'b1001));
        nv = 0;
        repeat (5) begin
            tick();
            if (evt_valid) nv++;
        end
        active = 1'b0;
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL basic_valid_cycles got=%0d exp=1", nv);
        end
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(4'(i));
            exp_q.push_back(ev(4'(i)));
            tick();
            checks++;
            if (level !== 4'(i + 1) || enable !== (i + 1 < 7)) begin
                errors++;
                $display("FAIL bp_fill%0d got=lvl%0d en%b exp=lvl%0d en%b",
                         i, level, enable, i + 1, (i + 1 < 7));
            end
        end
        active = 1'b0;
        evt_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (level !== 4'(6 - k) || enable !== (6 - k <= 4)) begin
                errors++;
                $display("FAIL bp_drain%0d got=lvl%0d en%b exp=lvl%0d en%b",
                         k, level, enable, 6 - k, (6 - k <= 4));
            end
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        tick();
        for (int j = 0; j < 11; j++) begin
            drive(4'(j));
            if (j < 8) exp_q.push_back(ev(4'(j)));
            tick();
            checks++;
            if (level !== 4'((j < 8) ? j + 1 : 8)) begin
                errors++;
                $display("FAIL ovf_level%0d got=%0d exp=%0d",
                         j, level, (j < 8) ? j + 1 : 8);
            end
        end
        active = 1'b0;
        checks++;
        if (drop !== 8'd3 || enable !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop got=%0d en%b exp=3 en0", drop, enable);
        end
    endtask

    task automatic test_full_pop();
        evt_ready = 1'b1;
        drive(4'd11);
        exp_q.push_back(ev(4'd11));
        tick();
        evt_ready = 1'b0;
        active = 1'b0;
        checks++;
        if (level !== 4'd8 || drop !== 8'd3) begin
            errors++;
            $display("FAIL full_pop got=lvl%0d drop%0d exp=lvl8 drop3",
                     level, drop);
        end
        for (int s = 0; s < 260; s++) begin
            drive(s[0] ? 4'd5 : 4'd10);
            tick();
        end
        active = 1'b0;
        checks++;
        if (drop !== 8'hff || level !== 4'd8) begin
            errors++;
            $display("FAIL drop_sat got=drop%0d lvl%0d exp=drop255 lvl8",
                     drop, level);
        end
        evt_ready = 1'b1;
        repeat (8) tick();
        evt_ready = 1'b0;
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL full_drain got=%0d exp=0", level);
        end
    endtask

    task automatic test_stop_drain();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'(i + 1));
            exp_q.push_back(ev(4'(i + 1)));
            tick();
        end
        active = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (enable !== 1'b0 || busy !== 1'b1 || level !== 4'd3) begin
            errors++;
            $display("FAIL stop got=en%b busy%b lvl%0d exp=en0 busy1 lvl3",
                     enable, busy, level);
        end
        evt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (level !== 4'(2 - k) || busy !== (k < 2) || enable !== 1'b0) begin
                errors++;
                $display("FAIL drain%0d got=lvl%0d busy%b en%b exp=lvl%0d busy%b en0",
                         k, level, busy, enable, 2 - k, (k < 2));
            end
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        t0 = cyc;
        checks++;
        if (drop !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart got=drop%0d busy%b exp=drop0 busy1", drop, busy);
        end
        for (int i = 0; i < 5; i++) begin
            drive(4'(i + 8));
            exp_q.push_back(ev(4'(i + 8)));
            tick();
        end
        active = 1'b0;
        checks++;
        if (level !== 4'd5) begin
            errors++;
            $display("FAIL mid_level got=%0d exp=5", level);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({enable, evt_valid, evt_data, level, drop, busy} !== '0) begin
            errors++;
            $display("FAIL async_rst got=%b%b %h %0d %0d %b exp=all zero",
                     enable, evt_valid, evt_data, level, drop, busy);
        end
        exp_q.delete();
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(4'(k));
            tick();
            checks++;
            if (evt_valid !== 1'b0 || level !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_rst%0d got=v%b lvl%0d busy%b exp=v0 lvl0 busy0",
                         k, evt_valid, level, busy);
            end
        end
        active = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_left got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_stop_drain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
